// File: rtl/ula_pkg.sv
// Shared definitions for the 6-bit ALU stage and its operand sequencer.
package ula_pkg;

  localparam int LARGURA = 6;
  localparam int OP_W    = 3;

  // Encoding is visible on the board LEDs, so the values are pinned explicitly.
  typedef enum logic [1:0] {
    ESPERA_A  = 2'd0,
    ESPERA_B  = 2'd1,
    ESPERA_OP = 2'd2,
    EMITE     = 2'd3
  } estado_t;

endpackage

// File: rtl/debounce_botao.sv
// Button conditioner: 2-flop synchronizer, stability counter and a single
// one-cycle pulse on each accepted press. Releases produce no pulse.
module debounce_botao #(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic entrada,
  output logic nivel,
  output logic pulso
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS) + 1;
  localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_nivel;
  logic          r_nivel_d;
  logic [CW-1:0] r_cnt;

  // Bring the raw button into the clock domain.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= entrada;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CICLOS edges.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_nivel <= 1'b0;
    end else if (r_sync2 == r_nivel) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_FIM) begin
      r_nivel <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Delayed copy of the debounced level for rising-edge detection.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_nivel_d <= 1'b0;
    end else begin
      r_nivel_d <= r_nivel;
    end
  end

  assign nivel = r_nivel;
  assign pulso = r_nivel & ~r_nivel_d;

endmodule

// File: rtl/ula_sequenciador.sv
// Operand sequencer: loads A, B, then op/mode from one switch bank on
// successive button presses and offers the bundle to the ALU via valid/ready.
module ula_sequenciador
  import ula_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [LARGURA-1:0] sw_dado,
  input  logic [OP_W-1:0]    sw_op,
  input  logic               sw_modo,
  input  logic               btn_carrega,
  input  logic               ula_pronto,
  output logic [LARGURA-1:0] A,
  output logic [LARGURA-1:0] B,
  output logic [OP_W-1:0]    operacao,
  output logic               modo,
  output logic               valido,
  output logic [1:0]         estado
);

  logic               w_nivel;
  logic               w_pulso;
  logic               w_carrega;
  logic               w_cap_a;
  logic               w_cap_b;
  logic               w_cap_op;
  estado_t            r_estado;
  estado_t            w_estado_prox;
  logic [LARGURA-1:0] r_a;
  logic [LARGURA-1:0] r_b;
  logic [OP_W-1:0]    r_op;
  logic               r_modo;

  debounce_botao #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_debounce (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .entrada  (btn_carrega),
    .nivel    (w_nivel),
    .pulso    (w_pulso)
  );

  // A load is acted on only while the debounced level is actually high.
  assign w_carrega = w_pulso & w_nivel;

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_estado <= ESPERA_A;
    end else begin
      r_estado <= w_estado_prox;
    end
  end

  // Next state and capture strobes; presses in EMITE and ready outside EMITE fall through.
  // NOTE: every output of this block is defaulted first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_estado_prox = r_estado;
    w_cap_a       = 1'b0;
    w_cap_b       = 1'b0;
    w_cap_op      = 1'b0;
    unique case (r_estado)
      ESPERA_A: begin
        if (w_carrega) begin
          w_cap_a       = 1'b1;
          w_estado_prox = ESPERA_B;
        end
      end
      ESPERA_B: begin
        if (w_carrega) begin
          w_cap_b       = 1'b1;
          w_estado_prox = ESPERA_OP;
        end
      end
      ESPERA_OP: begin
        if (w_carrega) begin
          w_cap_op      = 1'b1;
          w_estado_prox = EMITE;
        end
      end
      EMITE: begin
        if (ula_pronto) begin
          w_estado_prox = ESPERA_A;
        end
      end
      default: w_estado_prox = ESPERA_A;
    endcase
  end

  // Capture registers: written only on their capture edge, kept after transfer.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_modo <= 1'b0;
    end else begin
      if (w_cap_a) begin
        r_a <= sw_dado;
      end
      if (w_cap_b) begin
        r_b <= sw_dado;
      end
      if (w_cap_op) begin
        r_op   <= sw_op;
        r_modo <= sw_modo;
      end
    end
  end

  assign A        = r_a;
  assign B        = r_b;
  assign operacao = r_op;
  assign modo     = r_modo;
  assign valido   = (r_estado == EMITE);
  assign estado   = r_estado;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Bench for ula_sequenciador with a short debounce window. The reference model
// tracks how many fields of the bundle are loaded and when a press lands.
module tb_ula_sequenciador;
  import ula_pkg::*;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [LARGURA-1:0] sw_dado;
  logic [OP_W-1:0]    sw_op;
  logic               sw_modo;
  logic               btn;
  logic               pronto;
  logic [LARGURA-1:0] o_a;
  logic [LARGURA-1:0] o_b;
  logic [OP_W-1:0]    o_op;
  logic               o_modo;
  logic               o_valido;
  logic [1:0]         o_estado;

  ula_sequenciador #(
    .DEBOUNCE_CICLOS(N)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .sw_dado     (sw_dado),
    .sw_op       (sw_op),
    .sw_modo     (sw_modo),
    .btn_carrega (btn),
    .ula_pronto  (pronto),
    .A           (o_a),
    .B           (o_b),
    .operacao    (o_op),
    .modo        (o_modo),
    .valido      (o_valido),
    .estado      (o_estado)
  );

  always #10 clk = ~clk;

  int n_cmp    = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int cap_at   = -1;
  int n_valido = 0;

  // Model: m_fase = number of fields loaded (3 means bundle on offer).
  int                 m_fase = 0;
  logic [LARGURA-1:0] m_a    = '0;
  logic [LARGURA-1:0] m_b    = '0;
  logic [OP_W-1:0]    m_op   = '0;
  logic               m_modo = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bundle(input string tag);
    check({tag, ".A"},        32'(o_a),      32'(m_a));
    check({tag, ".B"},        32'(o_b),      32'(m_b));
    check({tag, ".operacao"}, 32'(o_op),     32'(m_op));
    check({tag, ".modo"},     32'(o_modo),   32'(m_modo));
    check({tag, ".estado"},   32'(o_estado), 32'(m_fase));
    check({tag, ".valido"},   32'(o_valido), (m_fase == 3) ? 32'd1 : 32'd0);
  endtask

  // One clock edge: update the model with what the edge sees, then compare.
  task automatic step();
    logic               pr;
    logic [LARGURA-1:0] d;
    logic [OP_W-1:0]    op;
    logic               md;
    pr = pronto;
    d  = sw_dado;
    op = sw_op;
    md = sw_modo;
    @(posedge clk);
    edge_n++;
    if (m_fase == 3) begin
      if (pr) m_fase = 0;
    end else if (edge_n == cap_at) begin
      case (m_fase)
        0:       m_a = d;
        1:       m_b = d;
        default: begin
          m_op   = op;
          m_modo = md;
        end
      endcase
      m_fase++;
    end
    #1;
    if (o_valido === 1'b1) n_valido++;
    check_bundle("step");
  endtask

  // Raw press of len cycles; a press of at least N cycles lands N+3 edges later.
  task automatic press(input int len, input int gap);
    btn = 1'b1;
    if (len >= N) cap_at = edge_n + 3 + N;
    repeat (len) step();
    btn = 1'b0;
    repeat (gap) step();
  endtask

  // Asynchronous reset pulse placed inside one clock period.
  task automatic do_reset();
    #4 reset = 1'b1;
    #2;
    check("rst.A",        32'(o_a),      32'd0);
    check("rst.B",        32'(o_b),      32'd0);
    check("rst.operacao", 32'(o_op),     32'd0);
    check("rst.modo",     32'(o_modo),   32'd0);
    check("rst.valido",   32'(o_valido), 32'd0);
    check("rst.estado",   32'(o_estado), 32'd0);
    #4 reset = 1'b0;
    m_fase = 0;
    m_a    = '0;
    m_b    = '0;
    m_op   = '0;
    m_modo = 1'b0;
    cap_at = -1;
  endtask

  initial begin
    reset   = 1'b1;
    sw_dado = '0;
    sw_op   = '0;
    sw_modo = 1'b0;
    btn     = 1'b0;
    pronto  = 1'b0;
    #15;
    check_bundle("reset");
    reset = 1'b0;
    repeat (2) step();

    // 1: full load and transfer
    sw_dado = 6'h2A;
    press(10, N + 6);
    sw_dado = 6'h15;
    press(10, N + 6);
    sw_op   = 3'b011;
    sw_modo = 1'b1;
    press(10, N + 6);
    check("t1.A",      32'(o_a),      32'h2A);
    check("t1.B",      32'(o_b),      32'h15);
    check("t1.op",     32'(o_op),     32'd3);
    check("t1.modo",   32'(o_modo),   32'd1);
    check("t1.valido", 32'(o_valido), 32'd1);
    repeat (5) step();
    check("t1.held", 32'(o_valido), 32'd1);
    pronto = 1'b1;
    step();
    pronto = 1'b0;
    check("t1.valido_off", 32'(o_valido), 32'd0);
    check("t1.estado_0",   32'(o_estado), 32'd0);
    check("t1.A_kept",     32'(o_a),      32'h2A);

    // 2: bounce rejection, then a clean press with exact capture timing
    sw_dado = 6'h0C;
    btn = 1'b1; repeat (2) step();
    btn = 1'b0; step();
    btn = 1'b1; repeat (3) step();
    btn = 1'b0; repeat (N + 8) step();
    check("t2.no_pulse", 32'(o_estado), 32'd0);
    btn    = 1'b1;
    cap_at = edge_n + 3 + N;
    repeat (N + 2) step();
    check("t2.before", 32'(o_estado), 32'd0);
    step();
    check("t2.capture", 32'(o_estado), 32'd1);
    repeat (10 - (N + 3)) step();
    btn = 1'b0;
    repeat (N + 6) step();
    check("t2.once", 32'(o_estado), 32'd1);

    // 3: held button gives one advance
    do_reset();
    step();
    sw_dado = 6'h33;
    press(100, N + 6);
    check("t3.estado", 32'(o_estado), 32'd1);
    check("t3.A",      32'(o_a),      32'h33);

    // 4: press while the bundle is on offer is ignored
    sw_dado = 6'h21;
    press(8, N + 6);
    sw_op   = 3'b101;
    sw_modo = 1'b0;
    press(8, N + 6);
    sw_dado = 6'h3E;
    sw_op   = 3'b010;
    sw_modo = 1'b1;
    press(10, N + 6);
    check("t4.estado", 32'(o_estado), 32'd3);
    check("t4.B",      32'(o_b),      32'h21);
    check("t4.op",     32'(o_op),     32'd5);
    pronto = 1'b1;
    step();
    pronto = 1'b0;
    step();

    // 5: ready already high when the bundle appears
    pronto = 1'b1;
    sw_dado = 6'h07;
    press(6, N + 6);
    sw_dado = 6'h38;
    press(6, N + 6);
    n_valido = 0;
    sw_op   = 3'b110;
    sw_modo = 1'b0;
    press(6, N + 6);
    check("t5.valido_cycles", 32'(n_valido), 32'd1);
    check("t5.estado",        32'(o_estado), 32'd0);
    check("t5.op",            32'(o_op),     32'd6);
    pronto = 1'b0;

    // 6: async reset with a partial sequence
    sw_dado = 6'h3F;
    press(6, N + 6);
    sw_dado = 6'h01;
    press(6, N + 6);
    check("t6.pre", 32'(o_estado), 32'd2);
    do_reset();
    step();
    sw_dado = 6'h2C;
    press(6, N + 6);
    check("t6.restart", 32'(o_estado), 32'd1);
    check("t6.A",       32'(o_a),      32'h2C);
    do_reset();
    step();

    // Randomized sequences with short bounces and random ready timing
    for (int it = 0; it < 10; it++) begin
      pronto = 1'($urandom_range(0, 1));
      for (int f = 0; f < 3; f++) begin
        sw_dado = 6'($urandom);
        sw_op   = 3'($urandom);
        sw_modo = 1'($urandom);
        if ($urandom_range(0, 2) == 0) press(int'($urandom_range(1, N - 1)), N + 4);
        press(int'($urandom_range(N, 12)), int'($urandom_range(N + 4, N + 8)));
      end
      pronto = 1'b0;
      repeat (int'($urandom_range(0, 4))) step();
      pronto = 1'b1;
      step();
      pronto = 1'b0;
      step();
    end
    check("rand.end", 32'(o_estado), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_sequenciador.md
# ula_sequenciador

Upstream operand sequencer for the 6-bit ALU stage. Loads operand A, operand B, then operation code and mode from one shared 6-bit switch bank using a single debounced load button. Presents the complete operand set to the ALU with a valid/ready handshake, and holds it stable until the ALU accepts it. Frees switch positions on the board and gives the ALU a clean, glitch-free operand bundle.

## Interface
- DEBOUNCE_CICLOS, default 50000: consecutive stable cycles required before a button level change is accepted (1 ms at 50 MHz). Legal range is ≥1.
- LARGURA, default 6: operand width (from package).

Ports:
- CLOCK_50  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- sw_dado  in  LARGURA  operand value source for A and B.
- sw_op  in  3  operation code source.
- sw_modo  in  1  mode source (1 = logical, 0 = arithmetic).
- btn_carrega  in  1  raw, asynchronous, bouncy load button (active-high).
- ula_pronto  in  1  ALU ready; a transfer occurs on an edge where valido && ula_pronto.
- A  out  LARGURA  captured operand A.
- B  out  LARGURA  captured operand B.
- operacao  out  3  captured op code.
- modo  out  1  captured mode.
- valido  out  1  operand bundle complete and stable.
- estado  out  2  current FSM state encoding, for LEDs.

## Operation
- **Button path:**
  - btn_carrega passes through a 2-flop synchronizer.
  - A counter runs while the synchronized level differs from the debounced level. It clears whenever the two are equal.
  - When the counter equals DEBOUNCE_CICLOS-1 on an edge where the levels still differ, the debounced level takes the synchronized value and the counter clears.
  - The press pulse is debounced AND NOT its one-cycle-delayed copy. It is exactly one cycle wide. Release produces no pulse.
- **FSM states (estado code):**
  - ESPERA_A (0): on a press pulse, A <= sw_dado, go to ESPERA_B.
  - ESPERA_B (1): on a press pulse, B <= sw_dado, go to ESPERA_OP.
  - ESPERA_OP (2): on a press pulse, operacao <= sw_op, modo <= sw_modo, go to EMITE.
  - EMITE (3): valido = 1. On an edge with ula_pronto = 1, go to ESPERA_A. Captured registers are not cleared; they keep the last values.
- valido is decoded from state and is high only in EMITE.
- A, B, operacao and modo change only on their capture edge. They are constant for the whole time valido is high.
- **Boundary conditions:**
  - A press pulse in EMITE is ignored and is not queued.
  - ula_pronto outside EMITE is ignored.
  - If ula_pronto is already high when EMITE is entered, the transfer completes on the first EMITE edge, so valido is high for exactly one cycle.
  - A bounce shorter than DEBOUNCE_CICLOS stable cycles never produces a pulse.
  - Holding the button produces exactly one pulse.
  - Reset asserted mid-sequence: all registers clear asynchronously. A, B, operacao, modo, valido, estado, the counter, the debounced level and the synchronizer all go to 0, and the FSM goes to ESPERA_A. A sequence that was partly loaded is discarded.
- **Reset values:** A=0, B=0, operacao=0, modo=0, valido=0, estado=0.

## Timing
- Raw button high and stable from edge k: sync2 is high after edge k+1 and the debounced level is high after edge k+1+DEBOUNCE_CICLOS.
- The pulse is high during the following cycle. The capture or FSM advance happens on edge k+2+DEBOUNCE_CICLOS.
- The handshake has zero extra latency: EMITE → ESPERA_A on the accepting edge.
- The switch inputs are sampled only on the capture edge. They need no synchronizer because the user holds them static around a press.

## Structure
- Package ula_pkg:
  - LARGURA = 6.
  - OP_W = 3.
  - typedef enum logic [1:0] estado_t {ESPERA_A, ESPERA_B, ESPERA_OP, EMITE}.
  - The ALU stage imports the same package.
- Sub-module debounce_botao, parameterised by DEBOUNCE_CICLOS. It contains the synchronizer, the counter (width $clog2(DEBOUNCE_CICLOS)+1) and the edge pulse. Ports: CLOCK_50, reset, entrada, nivel, pulso.
- The top level of this block contains only the FSM and the capture registers.

## Test plan
All scenarios use DEBOUNCE_CICLOS=4.
1. **Full load and transfer.** Press with sw_dado=6'h2A, then 6'h15, then sw_op=3'b011, sw_modo=1; ula_pronto=0. Required: A=2A, B=15, operacao=3, modo=1, valido=1 and held. Raise ula_pronto for one cycle → valido=0, estado=0 on that edge.
2. **Bounce rejection.** In ESPERA_A, toggle btn_carrega high 2 cycles, low 1, high 3, then low. Required: no pulse and estado stays 0. A later clean 10-cycle press gives exactly one pulse, and the capture lands 6 edges after the first raw-high sampling edge.
3. **Held button.** Hold btn_carrega high for 100 cycles in ESPERA_A. Required: exactly one advance, to estado=1.
4. **Press in EMITE.** Press while valido=1 and ula_pronto=0. Required: no change to state or registers.
5. **ula_pronto pre-asserted.** Keep ula_pronto=1 throughout the load sequence. Required: valido is high for exactly one cycle after the third capture.
6. **Async reset.** Assert reset mid-cycle in ESPERA_OP after A=3F, B=01. Required: all outputs read 0 before the next clock edge, and the next sequence starts at ESPERA_A.
